// File: rtl/down_count_reload.sv
`default_nettype none
// ============================================================================
// Module      : down_count_reload
// Description : Down counter with a reload register, one-shot or periodic
//               auto-reload, a one-cycle terminal-count flag and a two-state
//               IDLE/RUN control FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module down_count_reload #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,       // synchronous, active low
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,      // 0 = one-shot, 1 = periodic
    output logic [WIDTH-1:0] c,
    output logic             tc,
    output logic             busy
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [WIDTH-1:0] c_ONE = WIDTH'(1);

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_reload;
    logic [WIDTH-1:0] r_c;
    logic             r_tc;

    // Start value: a load on the same edge as start takes effect immediately.
    logic [WIDTH-1:0] w_start_val;
    assign w_start_val = load ? load_val : r_reload;

    // Reload register: written by load in any state, independent of control.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_reload <= '0;
        end else if (load) begin
            r_reload <= load_val;
        end
    end

    // Control FSM and counter; priority is stop, then start, then counting.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_c     <= '0;
            r_tc    <= 1'b0;
        end else if (stop) begin
            r_state <= S_IDLE;
            r_tc    <= 1'b0;
        end else if (start) begin
            r_state <= S_RUN;
            r_c     <= w_start_val;
            r_tc    <= 1'b0;
        end else if (r_state == S_RUN && en) begin
            if (r_c > c_ONE) begin
                r_c  <= r_c - c_ONE;
                r_tc <= 1'b0;
            end else if (r_c == c_ONE) begin
                // Expiry: tc coincides with the first cycle c reads zero.
                r_c  <= '0;
                r_tc <= 1'b1;
                if (!mode) begin
                    r_state <= S_IDLE;
                end
            end else begin
                // c == 0 while running: periodic reload, or a zero-reload
                // one-shot that expires immediately.
                if (mode) begin
                    r_c  <= r_reload;
                    r_tc <= (r_reload == '0);
                end else begin
                    r_tc    <= 1'b1;
                    r_state <= S_IDLE;
                end
            end
        end else begin
            // Idle, or running with the enable low: hold c, clear tc.
            r_tc <= 1'b0;
        end
    end

    assign c    = r_c;
    assign tc   = r_tc;
    assign busy = (r_state == S_RUN);

endmodule
`default_nettype wire
